// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point defaults, PLAN sigmoid constants and FSM encoding for the
// cost/accuracy evaluation block.
package rnn_fixed_pkg;

    localparam int QN_DEF       = 6;
    localparam int QM_DEF       = 11;
    localparam int BITWIDTH_DEF = QN_DEF + QM_DEF + 1;

    // PLAN breakpoints and offsets on the default QM grid
    localparam int PLAN_BP_HI   = 10240;  // 5.0
    localparam int PLAN_BP_MID  = 4864;   // 2.375
    localparam int PLAN_BP_LO   = 2048;   // 1.0
    localparam int PLAN_OFF_HI  = 1728;   // 0.84375
    localparam int PLAN_OFF_MID = 1280;   // 0.625
    localparam int PLAN_OFF_LO  = 1024;   // 0.5
    localparam int PLAN_ONE     = 2048;   // 1.0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Rescale a default-grid constant onto a QM-fraction grid of another width
    function automatic int plan_q(input int v, input int qm);
        return (qm >= QM_DEF) ? (v << (qm - QM_DEF)) : (v >>> (QM_DEF - qm));
    endfunction

endpackage

// File: rtl/sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid on a signed QN.QM input;
// output is unsigned on the QM grid, range [0, 1.0].
module sigmoid_plan
    import rnn_fixed_pkg::*;
#(
    parameter int QN = QN_DEF,
    parameter int QM = QM_DEF
) (
    input  logic signed [QN+QM:0] i_x,
    output logic        [QN+QM:0] o_s
);

    localparam int BW = QN + QM + 1;

    localparam logic [BW-1:0] C_BP_HI    = BW'(plan_q(PLAN_BP_HI, QM));
    localparam logic [BW-1:0] C_BP_MID   = BW'(plan_q(PLAN_BP_MID, QM));
    localparam logic [BW-1:0] C_BP_LO    = BW'(plan_q(PLAN_BP_LO, QM));
    localparam logic [BW-1:0] C_OFF_HI   = BW'(plan_q(PLAN_OFF_HI, QM));
    localparam logic [BW-1:0] C_OFF_MID  = BW'(plan_q(PLAN_OFF_MID, QM));
    localparam logic [BW-1:0] C_OFF_LO   = BW'(plan_q(PLAN_OFF_LO, QM));
    localparam logic [BW-1:0] C_ONE      = BW'(plan_q(PLAN_ONE, QM));
    localparam logic [BW-1:0] C_MOST_NEG = {1'b1, {(BW-1){1'b0}}};

    logic [BW-1:0] w_mag;
    logic [BW-1:0] w_pos;

    always_comb begin
        w_mag = $unsigned(i_x);
        // The most-negative code has no positive twin; pin it into the saturated region
        if (i_x == C_MOST_NEG) begin
            w_mag = {1'b0, {(BW-1){1'b1}}};
        end else if (i_x[BW-1]) begin
            w_mag = $unsigned(-i_x);
        end

        if (w_mag >= C_BP_HI) begin
            w_pos = C_ONE;
        end else if (w_mag >= C_BP_MID) begin
            w_pos = (w_mag >> 5) + C_OFF_HI;
        end else if (w_mag >= C_BP_LO) begin
            w_pos = (w_mag >> 3) + C_OFF_MID;
        end else begin
            w_pos = (w_mag >> 2) + C_OFF_LO;
        end

        o_s = i_x[BW-1] ? (C_ONE - w_pos) : w_pos;
    end

endmodule

// File: rtl/cost_function_unit.sv
// Serial per-channel sigmoid + squared-error cost against binary targets, with
// saturating misclassification/sample statistics and a one-cycle result strobe.
module cost_function_unit
    import rnn_fixed_pkg::*;
#(
    parameter int OUTPUT_SZ    = 1,
    parameter int QN           = QN_DEF,
    parameter int QM           = QM_DEF,
    parameter int BITWIDTH     = QN + QM + 1,
    parameter int CNT_BITWIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dataReadyP,
    input  logic [OUTPUT_SZ*BITWIDTH-1:0] networkOutput,
    input  logic [OUTPUT_SZ-1:0]          target,
    input  logic                          clearStats,
    output logic                          newCostFunc,
    output logic [BITWIDTH-1:0]           costFunc,
    output logic [OUTPUT_SZ-1:0]          prediction,
    output logic [CNT_BITWIDTH-1:0]       errorCount,
    output logic [CNT_BITWIDTH-1:0]       sampleCount,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
    localparam int ACC_W = BITWIDTH + $clog2(OUTPUT_SZ) + 1;
    localparam int SQ_W  = 2 * BITWIDTH + 2;
    localparam int PC_W  = $clog2(OUTPUT_SZ + 1);
    localparam logic [ACC_W-1:0] COST_MAX = ACC_W'((1 << (BITWIDTH - 1)) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUTPUT_SZ - 1);

    function automatic logic [BITWIDTH-1:0] sat_cost(input logic [ACC_W-1:0] a);
        return (a > COST_MAX) ? COST_MAX[BITWIDTH-1:0] : a[BITWIDTH-1:0];
    endfunction

    function automatic logic [CNT_BITWIDTH-1:0] sat_add(input logic [CNT_BITWIDTH-1:0] a,
                                                        input logic [PC_W-1:0] b);
        logic [CNT_BITWIDTH:0] sum;
        sum = {1'b0, a} + (CNT_BITWIDTH + 1)'(b);
        return sum[CNT_BITWIDTH] ? '1 : sum[CNT_BITWIDTH-1:0];
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [OUTPUT_SZ-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUTPUT_SZ; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    state_t                        r_state;
    logic                          r_drp_q;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_drain;
    logic                          r_vld_p1;
    logic                          r_new;
    logic [BITWIDTH-1:0]           r_cost;
    logic [OUTPUT_SZ-1:0]          r_pred;
    logic [CNT_BITWIDTH-1:0]       r_err;
    logic [CNT_BITWIDTH-1:0]       r_smp;
    logic                          r_busy;
    logic                          r_ovr;

    logic [OUTPUT_SZ*BITWIDTH-1:0] r_x;
    logic [OUTPUT_SZ-1:0]          r_tgt;
    logic [BITWIDTH-1:0]           r_s_p1;
    logic                          r_tgt_p1;
    logic [ACC_W-1:0]              r_acc_p2;

    logic                          w_start;
    logic signed [BITWIDTH-1:0]    w_x_sel;
    logic [BITWIDTH-1:0]           w_sig;
    logic signed [BITWIDTH:0]      w_d;
    logic signed [SQ_W-1:0]        w_dx;
    logic signed [SQ_W-1:0]        w_sq;
    logic [ACC_W-1:0]              w_add;
    logic [OUTPUT_SZ-1:0]          w_pred;

    assign w_start = dataReadyP & ~r_drp_q;
    assign w_x_sel = r_x[r_idx*BITWIDTH +: BITWIDTH];

    always_comb begin
        w_pred = '0;
        for (int c = 0; c < OUTPUT_SZ; c++) w_pred[c] = ~r_x[c*BITWIDTH + BITWIDTH - 1];
    end

    // Stage 0 -> 1: sigmoid of the issued channel
    sigmoid_plan #(.QN(QN), .QM(QM)) u_sigmoid (
        .i_x (w_x_sel),
        .o_s (w_sig)
    );

    // Stage 1 -> 2: squared error, rescaled to the QM grid and accumulated
    assign w_d   = $signed({{(BITWIDTH-QM){1'b0}}, r_tgt_p1, {QM{1'b0}}}) - $signed({1'b0, r_s_p1});
    assign w_dx  = SQ_W'(w_d);
    assign w_sq  = w_dx * w_dx;
    assign w_add = ACC_W'($unsigned(w_sq >>> QM));

    always_ff @(posedge clock) begin
        if (r_state == ST_IDLE && w_start) begin
            r_x      <= networkOutput;
            r_tgt    <= target;
            r_acc_p2 <= '0;
        end
        if (r_state == ST_RUN) begin
            r_s_p1   <= w_sig;
            r_tgt_p1 <= r_tgt[r_idx];
        end
        if (r_vld_p1) r_acc_p2 <= r_acc_p2 + w_add;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_drp_q  <= 1'b0;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_new    <= 1'b0;
            r_cost   <= '0;
            r_pred   <= '0;
            r_err    <= '0;
            r_smp    <= '0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_drp_q  <= dataReadyP;
            r_new    <= 1'b0;
            r_vld_p1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_vld_p1 <= 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: let the last channel clear stage 1 and stage 2
                    r_drain <= 1'b1;
                    if (r_drain) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_new   <= 1'b1;
                    r_cost  <= sat_cost(r_acc_p2);
                    r_pred  <= w_pred;
                    r_err   <= sat_add(r_err, popcount(w_pred ^ r_tgt));
                    r_smp   <= sat_add(r_smp, PC_W'(1));
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_start && r_state != ST_IDLE) r_ovr <= 1'b1;
            if (clearStats) begin
                r_err <= '0;
                r_smp <= '0;
                r_ovr <= 1'b0;
            end
        end
    end

    assign newCostFunc = r_new;
    assign costFunc    = r_cost;
    assign prediction  = r_pred;
    assign errorCount  = r_err;
    assign sampleCount = r_smp;
    assign busy        = r_busy;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_cost_function_unit.sv
// Directed bench for cost_function_unit: one-channel, two-channel and
// narrow-counter instances driven from a shared clock and reset.
module tb_cost_function_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // dut1: OUTPUT_SZ=1, 16-bit counters
    logic        d1_drp = 0, d1_clr = 0, d1_new, d1_busy, d1_ovr;
    logic [17:0] d1_x = '0, d1_cost;
    logic [0:0]  d1_tgt = '0, d1_pred;
    logic [15:0] d1_err, d1_smp;

    // dut2: OUTPUT_SZ=2
    logic        d2_drp = 0, d2_clr = 0, d2_new, d2_busy, d2_ovr;
    logic [35:0] d2_x = '0;
    logic [17:0] d2_cost;
    logic [1:0]  d2_tgt = '0, d2_pred;
    logic [15:0] d2_err, d2_smp;

    // dut3: OUTPUT_SZ=1, 4-bit counters
    logic        d3_drp = 0, d3_clr = 0, d3_new, d3_busy, d3_ovr;
    logic [17:0] d3_x = '0, d3_cost;
    logic [0:0]  d3_tgt = '0, d3_pred;
    logic [3:0]  d3_err, d3_smp;

    cost_function_unit #(.OUTPUT_SZ(1), .CNT_BITWIDTH(16)) u_dut1 (
        .clock(clk), .reset(rst_n), .dataReadyP(d1_drp), .networkOutput(d1_x), .target(d1_tgt),
        .clearStats(d1_clr), .newCostFunc(d1_new), .costFunc(d1_cost), .prediction(d1_pred),
        .errorCount(d1_err), .sampleCount(d1_smp), .busy(d1_busy), .overrun(d1_ovr));

    cost_function_unit #(.OUTPUT_SZ(2), .CNT_BITWIDTH(16)) u_dut2 (
        .clock(clk), .reset(rst_n), .dataReadyP(d2_drp), .networkOutput(d2_x), .target(d2_tgt),
        .clearStats(d2_clr), .newCostFunc(d2_new), .costFunc(d2_cost), .prediction(d2_pred),
        .errorCount(d2_err), .sampleCount(d2_smp), .busy(d2_busy), .overrun(d2_ovr));

    cost_function_unit #(.OUTPUT_SZ(1), .CNT_BITWIDTH(4)) u_dut3 (
        .clock(clk), .reset(rst_n), .dataReadyP(d3_drp), .networkOutput(d3_x), .target(d3_tgt),
        .clearStats(d3_clr), .newCostFunc(d3_new), .costFunc(d3_cost), .prediction(d3_pred),
        .errorCount(d3_err), .sampleCount(d3_smp), .busy(d3_busy), .overrun(d3_ovr));

    // Launch one evaluation on dut1; lat is the negedge index of the pulse, or 0 if no pulse arrives
    task automatic run1(input logic [17:0] x, input logic t, output int lat, output int bcnt);
        @(negedge clk);
        d1_x = x; d1_tgt = t; d1_drp = 1'b1;
        lat = 0; bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d1_busy) bcnt++;
            if (d1_new) begin lat = k; break; end
        end
        d1_drp = 1'b0;
    endtask

    task automatic run3(input logic [17:0] x, input logic t, output int lat);
        @(negedge clk);
        d3_x = x; d3_tgt = t; d3_drp = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d3_new) begin lat = k; break; end
        end
        d3_drp = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (d1_busy !== 1'b0 || d1_new !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: busy=%b new=%b expected 0 0", d1_busy, d1_new); end
        n_checks++; if (d1_cost !== 18'd0 || d1_pred !== 1'b0) begin n_fail++; $display("FAIL reset_data: cost=%0d pred=%b expected 0 0", d1_cost, d1_pred); end
        n_checks++; if (d1_err !== 16'd0 || d1_smp !== 16'd0 || d1_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_stats: err=%0d smp=%0d ovr=%b expected 0 0 0", d1_err, d1_smp, d1_ovr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run1(18'd0, 1'b1, lat, bcnt);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_checks++; if (bcnt != 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bcnt); end
        n_checks++; if (d1_cost !== 18'd512) begin n_fail++; $display("FAIL basic_cost: got %0d expected 512", d1_cost); end
        n_checks++; if (d1_pred !== 1'b1) begin n_fail++; $display("FAIL basic_pred: got %b expected 1", d1_pred); end
        n_checks++; if (d1_err !== 16'd0 || d1_smp !== 16'd1) begin n_fail++; $display("FAIL basic_stats: err=%0d smp=%0d expected 0 1", d1_err, d1_smp); end
        n_checks++; if (d1_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b expected 0", d1_busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (d1_new !== 1'b0 || d1_cost !== 18'd512) begin n_fail++; $display("FAIL basic_hold: new=%b cost=%0d expected 0 512", d1_new, d1_cost); end
    endtask

    task automatic test_vectors();
        int vx   [9] = '{-2048, 12288, 12288, -131072, 4864, 4863, 2047, -4864, 10240};
        int vt   [9] = '{0,     1,     0,     0,       1,    1,    0,    0,     0};
        int vc   [9] = '{128,   0,     2048,  0,       13,   12,   1150, 13,    2048};
        int vp   [9] = '{0,     1,     1,     0,       1,    1,    1,    0,     1};
        int verr [9] = '{0,     0,     1,     1,       1,    1,    2,    2,     3};
        int lat, bcnt;
        for (int i = 0; i < 9; i++) begin
            run1(18'(vx[i]), vt[i][0], lat, bcnt);
            n_checks++; if (lat != 5) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 5", i, lat); end
            n_checks++; if (d1_cost !== 18'(vc[i])) begin n_fail++; $display("FAIL vec%0d_cost: got %0d expected %0d", i, d1_cost, vc[i]); end
            n_checks++; if (d1_pred !== vp[i][0]) begin n_fail++; $display("FAIL vec%0d_pred: got %b expected %0d", i, d1_pred, vp[i]); end
            n_checks++; if (d1_err !== 16'(verr[i]) || d1_smp !== 16'(i + 2)) begin n_fail++; $display("FAIL vec%0d_stats: err=%0d smp=%0d expected %0d %0d", i, d1_err, d1_smp, verr[i], i + 2); end
        end
    endtask

    task automatic test_two_channel();
        int lat = 0, bcnt = 0;
        @(negedge clk);
        d2_x = {18'h3F800, 18'h00000}; d2_tgt = 2'b01; d2_drp = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d2_busy) bcnt++;
            if (d2_new) begin lat = k; break; end
        end
        d2_drp = 1'b0;
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL two_latency: got %0d expected 6", lat); end
        n_checks++; if (bcnt != 5) begin n_fail++; $display("FAIL two_busy_cycles: got %0d expected 5", bcnt); end
        n_checks++; if (d2_cost !== 18'd640) begin n_fail++; $display("FAIL two_cost: got %0d expected 640", d2_cost); end
        n_checks++; if (d2_pred !== 2'b01) begin n_fail++; $display("FAIL two_pred: got %b expected 01", d2_pred); end
        n_checks++; if (d2_err !== 16'd0 || d2_smp !== 16'd1) begin n_fail++; $display("FAIL two_stats: err=%0d smp=%0d expected 0 1", d2_err, d2_smp); end
    endtask

    task automatic test_overrun_clear();
        int pulses = 0;
        @(negedge clk);
        d1_x = 18'd0; d1_tgt = 1'b1; d1_drp = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (d1_new) pulses++;
            if (k == 1) d1_drp = 1'b0;
            if (k == 2) d1_drp = 1'b1;
            if (k == 10) d1_drp = 1'b0;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
        n_checks++; if (d1_ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", d1_ovr); end
        n_checks++; if (d1_err !== 16'd3 || d1_smp !== 16'd11) begin n_fail++; $display("FAIL overrun_stats: err=%0d smp=%0d expected 3 11", d1_err, d1_smp); end
        d1_clr = 1'b1;
        @(negedge clk);
        d1_clr = 1'b0;
        n_checks++; if (d1_ovr !== 1'b0 || d1_err !== 16'd0 || d1_smp !== 16'd0) begin n_fail++; $display("FAIL clear_stats: ovr=%b err=%0d smp=%0d expected 0 0 0", d1_ovr, d1_err, d1_smp); end
        n_checks++; if (d1_cost !== 18'd512) begin n_fail++; $display("FAIL clear_keeps_cost: got %0d expected 512", d1_cost); end
    endtask

    task automatic test_clear_in_done();
        int lat = 0;
        @(negedge clk);
        d1_x = 18'd12288; d1_tgt = 1'b0; d1_drp = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d1_new) begin lat = k; break; end
            if (k == 4) d1_clr = 1'b1;
        end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL clrdone_latency: got %0d expected 5", lat); end
        n_checks++; if (d1_cost !== 18'd2048) begin n_fail++; $display("FAIL clrdone_cost: got %0d expected 2048", d1_cost); end
        n_checks++; if (d1_err !== 16'd0 || d1_smp !== 16'd0) begin n_fail++; $display("FAIL clrdone_stats: err=%0d smp=%0d expected 0 0", d1_err, d1_smp); end
        d1_clr = 1'b0; d1_drp = 1'b0;
    endtask

    task automatic test_counter_saturation();
        int lat, tmo = 0;
        for (int i = 0; i < 20; i++) begin
            run3(18'd12288, 1'b0, lat);
            if (lat != 5) tmo++;
            if (i == 13) begin
                n_checks++; if (d3_err !== 4'd14 || d3_smp !== 4'd14) begin n_fail++; $display("FAIL sat_pre: err=%0d smp=%0d expected 14 14", d3_err, d3_smp); end
            end
        end
        n_checks++; if (tmo != 0) begin n_fail++; $display("FAIL sat_latency: %0d samples off latency, expected 0", tmo); end
        n_checks++; if (d3_err !== 4'd15) begin n_fail++; $display("FAIL sat_err: got %0d expected 15", d3_err); end
        n_checks++; if (d3_smp !== 4'd15) begin n_fail++; $display("FAIL sat_smp: got %0d expected 15", d3_smp); end
    endtask

    task automatic test_reset_midrun();
        int pulses = 0;
        @(negedge clk);
        d3_x = 18'd0; d3_tgt = 1'b1; d3_drp = 1'b1;
        @(negedge clk);
        n_checks++; if (d3_busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b expected 1", d3_busy); end
        rst_n = 1'b0; d3_drp = 1'b0;
        #1;
        n_checks++; if (d3_busy !== 1'b0 || d3_new !== 1'b0) begin n_fail++; $display("FAIL midrun_ctrl: busy=%b new=%b expected 0 0", d3_busy, d3_new); end
        n_checks++; if (d3_cost !== 18'd0 || d3_err !== 4'd0 || d3_smp !== 4'd0) begin n_fail++; $display("FAIL midrun_data: cost=%0d err=%0d smp=%0d expected 0 0 0", d3_cost, d3_err, d3_smp); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d3_new) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrun_no_pulse: got %0d pulses expected 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_two_channel();
        test_overrun_clear();
        test_clear_in_done();
        test_counter_saturation();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
        $fatal(1);
    end

endmodule

// File: doc/cost_function_unit.md
Name: cost_function_unit

Overview:
Hardware replacement for the behavioural cost/accuracy evaluation that currently sits between the output perceptron (array_prod) and the training port of network.
- Takes the perceptron's fixed-point outputs and computes a shift-add sigmoid per output channel.
- Forms the squared-error cost against binary targets and presents it on the newCostFunc/costFunc pair expected by network.
- Keeps saturating misclassification and sample statistics. Generalised to OUTPUT_SZ channels, processed serially.

Parameters:
OUTPUT_SZ, 1, number of output channels evaluated per sample
QN, 6, integer bits of the fixed-point format
QM, 11, fractional bits of the fixed-point format
BITWIDTH, QN+QM+1, derived word width (signed two's complement)
CNT_BITWIDTH, 16, width of the statistics counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dataReadyP  in  1  perceptron result valid (level); rising edge starts one evaluation
networkOutput  in  OUTPUT_SZ*BITWIDTH  perceptron outputs; channel c at [c*BITWIDTH +: BITWIDTH]
target  in  OUTPUT_SZ  binary label per channel
clearStats  in  1  synchronous clear of errorCount, sampleCount, overrun
newCostFunc  out  1  one-cycle pulse, costFunc valid
costFunc  out  BITWIDTH  summed squared error, unsigned QM-fraction format
prediction  out  OUTPUT_SZ  thresholded sigmoid per channel
errorCount  out  CNT_BITWIDTH  saturating count of mismatched channel bits
sampleCount  out  CNT_BITWIDTH  saturating count of completed evaluations
busy  out  1  evaluation in progress
overrun  out  1  sticky: start edge seen while busy

Behaviour:
- Reset (reset=0, asynchronous): all outputs and counters 0, FSM to IDLE, any in-flight evaluation discarded with no pulse.
- Start detection: dataReadyP is registered internally. A start is a sample at edge N with dataReadyP=1 where the previous sample was 0. A level held high gives exactly one start.
- At a start in IDLE: networkOutput and target are captured at edge N and busy=1 from N.
- At a start while busy: the start is ignored and overrun is set (sticky).
- FSM states:
  - IDLE -> RUN on start.
  - RUN issues channel index 0..OUTPUT_SZ-1, one per cycle; -> DRAIN after the last issue.
  - DRAIN waits for the 2-stage pipeline to empty; -> DONE.
  - DONE drives newCostFunc=1 for one cycle, updates costFunc, prediction and counters; -> IDLE.
- Latency: newCostFunc is high exactly in the cycle after edge N+OUTPUT_SZ+3. busy drops in that same cycle. A new start can be accepted one cycle later.
- Pipeline stage 1: sigmoid via sub-module (PLAN approximation), computed on |x| with x=networkOutput channel:
  - |x|>=5.0 -> 1.0
  - 2.375<=|x|<5.0 -> |x|/32+0.84375
  - 1.0<=|x|<2.375 -> |x|/8+0.625
  - |x|<1.0 -> |x|/4+0.5
  - x<0 -> 1.0 minus the above.
  - Result is unsigned, range [0, 2^QM], BITWIDTH wide. Truncate on shifts.
  - x = most-negative value: treat |x| as saturated (>=5.0).
- Stage 2:
  - d = target*2^QM - s (signed, BITWIDTH+1).
  - sq = d*d (2*BITWIDTH+2), then shift right by QM.
  - Accumulate into a BITWIDTH+log2(OUTPUT_SZ)+1 register, saturating to 2^(BITWIDTH-1)-1 at output.
- prediction[c] = (x>=0). Mismatches = popcount(prediction XOR target).
- Counter updates in DONE:
  - errorCount += mismatches.
  - sampleCount += 1.
  - Both saturate at all-ones.
- clearStats:
  - Zeroes errorCount, sampleCount and overrun; does not affect costFunc or the FSM.
  - If asserted in the DONE cycle, clear wins: the counters read 0 after that edge.
- Held outputs: costFunc and prediction hold their values until the next DONE.

Decomposition:
- Shared package rnn_fixed_pkg:
  - QN, QM and BITWIDTH defaults.
  - PLAN breakpoints (5.0, 2.375, 1.0) and offsets (0.84375, 0.625, 0.5) as QM-scaled constants.
  - FSM state encoding.
- One combinational sub-module, sigmoid_plan #(QN,QM): input BITWIDTH signed, output BITWIDTH unsigned.

Test Plan:
- OUTPUT_SZ=1, QM=11, x=0, target=1: s=1024, newCostFunc 4 cycles after the start edge, costFunc=512, prediction=1, errorCount=0, sampleCount=1.
- x=-2048 (-1.0), target=0: s=512, costFunc=128, prediction=0.
- x=12288 (6.0): with target=1, costFunc=0; then with target=0, costFunc=2048 and errorCount increments by 1.
- OUTPUT_SZ=2, x={0,-2048}, target={1,0} (channel 0 first): costFunc=640, pulse 5 cycles after the start, busy high for exactly 5 cycles.
- dataReadyP held high 10 cycles, with a second rising edge inserted mid-RUN: exactly one newCostFunc pulse and overrun=1. clearStats then returns overrun, errorCount and sampleCount to 0.
- CNT_BITWIDTH=4, 20 mismatching samples: errorCount stops at 15. reset=0 asserted mid-RUN: outputs 0 immediately and no pulse follows.
